data_memory_mp: RTL and testbench

DATA_MEMORY_MP -- requirements
Module: data_memory_mp

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_memory_mp_if.sv | 32 +++
 rtl/data_mem_clear_seq.sv | 57 +++++
 rtl/data_memory_mp.sv | 87 ++++++++
 tb/tb_data_memory_mp.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and constants for the multi-port data memory
// Contents:
//   clr_state_t     : clear sequencer state (IDLE, CLEAR)
//   DEFAULT_ADDR_W  : default word address width
//   DEFAULT_DATA_W  : default word width
//   BE_W            : byte enables per word at the default width
package data_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 32;
    localparam int BE_W           = DEFAULT_DATA_W / 8;

endpackage

// File: rtl/data_memory_mp_if.sv
// rtl/data_memory_mp_if.sv - port bundle for the multi-port data memory
// Signals (packed per port, port i at [i*W +: W]):
//   rd_addr/rd_data           : NRD synchronous read ports
//   wr_en/wr_addr/wr_data/wr_be : NWR byte-masked write ports
//   clear_req                 : one-cycle request to zero the array
//   busy                      : high while the clear sweep runs
// Modports: master (client side), slave (memory side).
interface data_memory_mp_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 4
) ();
    logic [NRD*ADDR_W-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0]     rd_data;
    logic [NWR-1:0]            wr_en;
    logic [NWR*ADDR_W-1:0]     wr_addr;
    logic [NWR*DATA_W-1:0]     wr_data;
    logic [NWR*(DATA_W/8)-1:0] wr_be;
    logic                      clear_req;
    logic                      busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_be, clear_req,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_be, clear_req,
        output rd_data, busy
    );
endinterface

// File: rtl/data_mem_clear_seq.sv
// rtl/data_mem_clear_seq.sv - clear FSM and sweep counter for the data memory
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear_req    : start a sweep when idle (ignored mid-sweep)
//   busy         : registered, high for exactly 2**ADDR_W cycles per sweep
//   clr_we       : zero the word at clr_addr on this edge
//   clr_addr     : current sweep address
module data_mem_clear_seq
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    clr_state_t      state;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] cnt_nxt;

    // The extra MSB lets the last address be recognised as the step into DEPTH.
    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // This edge zeroes the word at cnt; leave once the last one is done.
                    if (cnt_nxt[ADDR_W]) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
            endcase
        end
    end

    assign clr_we   = busy;
    assign clr_addr = cnt[ADDR_W-1:0];
endmodule

// File: rtl/data_memory_mp.sv
// rtl/data_memory_mp.sv - multi-port byte-masked data memory with sweep clear
// Ports:
//   clock, reset : clock and synchronous active-high reset (reset starts a clear)
//   bus          : data_memory_mp_if.slave (read/write ports, clear_req, busy)
// Reads have one cycle of latency and are read-first by default.
// Define DATA_MEM_BYPASS_EN for write-first forwarding of same-cycle writes.
module data_memory_mp
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NRD    = 4,
    parameter int NWR    = 4
) (
    input  logic clock,
    input  logic reset,
    data_memory_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBE   = DATA_W / 8;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  busy;
    logic                  clr_we;
    logic [ADDR_W-1:0]     clr_addr;
    logic [NRD*DATA_W-1:0] rd_next;
    logic [NRD*DATA_W-1:0] rd_q;

    data_mem_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .clear_req(bus.clear_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Ascending port order makes the highest-index port win each byte.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (!reset) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j]) begin
                    for (int b = 0; b < NBE; b++) begin
                        if (bus.wr_be[j*NBE + b]) begin
                            mem[bus.wr_addr[j*ADDR_W +: ADDR_W]][b*8 +: 8] <= bus.wr_data[j*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_next[i*DATA_W +: DATA_W] = mem[bus.rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef DATA_MEM_BYPASS_EN
            // Overlay bytes written this cycle, same priority as the array write.
            for (int j = 0; j < NWR; j++) begin
                if (!busy && bus.wr_en[j] &&
                    bus.wr_addr[j*ADDR_W +: ADDR_W] == bus.rd_addr[i*ADDR_W +: ADDR_W]) begin
                    for (int b = 0; b < NBE; b++) begin
                        if (bus.wr_be[j*NBE + b]) begin
                            rd_next[i*DATA_W + b*8 +: 8] = bus.wr_data[j*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
`endif
        end
    end

    // Zeroing rd_q during a sweep keeps the first post-sweep cycle clean.
    always_ff @(posedge clock) begin
        if (reset || busy) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_next;
        end
    end

    // Mask covers the cycle right after clear_req, when rd_q still holds a read.
    assign bus.rd_data = busy ? '0 : rd_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_data_memory_mp.sv
// tb/tb_data_memory_mp.sv - scoreboard bench for data_memory_mp
module tb_data_memory_mp;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 4;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic            busy;
        logic [NRD*DW-1:0] rd;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    data_memory_mp_if #(.ADDR_W(AW), .DATA_W(DW), .NRD(NRD), .NWR(NWR)) bus ();

    data_memory_mp #(.ADDR_W(AW), .DATA_W(DW), .NRD(NRD), .NWR(NWR)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [DW-1:0] ref_mem [DEPTH];
    int          busy_left = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          run_len;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        bus.rd_addr   = '0;
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_be     = '0;
        bus.clear_req = 1'b0;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        bus.wr_en[j]              = 1'b1;
        bus.wr_addr[j*AW +: AW]   = a;
        bus.wr_data[j*DW +: DW]   = d;
        bus.wr_be[j*BEW +: BEW]   = be;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        bus.rd_addr[i*AW +: AW] = a;
    endtask

    // Reference model: a clear zeroes the array at once and blocks writes for
    // DEPTH cycles; reads return the word before (or, with forwarding, after)
    // this cycle's writes, and read 0 whenever the memory is or was just busy.
    task automatic tick();
        exp_t          e;
        logic          busy_now;
        logic [AW-1:0] a;
        logic [DW-1:0] old_rd [NRD];
        logic [DW-1:0] new_rd [NRD];
        busy_now = (busy_left > 0);
        for (int i = 0; i < NRD; i++) old_rd[i] = ref_mem[bus.rd_addr[i*AW +: AW]];
        if (!reset && !busy_now) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j]) begin
                    a = bus.wr_addr[j*AW +: AW];
                    for (int b = 0; b < BEW; b++)
                        if (bus.wr_be[j*BEW + b]) ref_mem[a][b*8 +: 8] = bus.wr_data[j*DW + b*8 +: 8];
                end
            end
        end
        for (int i = 0; i < NRD; i++) new_rd[i] = ref_mem[bus.rd_addr[i*AW +: AW]];
        if (reset || (!busy_now && bus.clear_req)) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
            busy_left = DEPTH;
        end else if (busy_now) begin
            busy_left--;
        end
        e.busy = (busy_left > 0);
        e.rd   = '0;
        if (!e.busy && !busy_now && !reset) begin
            for (int i = 0; i < NRD; i++) begin
`ifdef DATA_MEM_BYPASS_EN
                e.rd[i*DW +: DW] = new_rd[i];
`else
                e.rd[i*DW +: DW] = old_rd[i];
`endif
            end
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Counts busy cycles starting with the one just after the last tick.
    task automatic measure_busy(output int len);
        len = bus.busy ? 1 : 0;
        for (int k = 0; k < DEPTH + 20; k++) begin
            if (!bus.busy) break;
            tick();
            if (bus.busy) len++;
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("busy", {31'b0, bus.busy}, {31'b0, mon_e.busy});
            for (int i = 0; i < NRD; i++)
                check($sformatf("rd_data[%0d]", i), bus.rd_data[i*DW +: DW], mon_e.rd[i*DW +: DW]);
        end
    end

    initial begin
        logic [DW-1:0] byp_exp;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        idle_inputs();

        // Reset for one cycle, then the sweep must last exactly DEPTH cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        measure_busy(run_len);
        check("reset_busy_len", run_len, DEPTH);
        set_rd(0, 9'd511);
        tick();
        check("addr511_after_reset", bus.rd_data[0 +: DW], 32'h0);

        // Single full-word write, read back on another port.
        idle_inputs();
        set_wr(0, 9'h010, 32'hDEADBEEF, 4'hF);
        tick();
        idle_inputs();
        set_rd(2, 9'h010);
        tick();
        check("write_readback", bus.rd_data[2*DW +: DW], 32'hDEADBEEF);

        // Same-address collision: port 3 owns the low bytes, port 1 the rest.
        idle_inputs();
        set_wr(1, 9'h020, 32'h11111111, 4'hF);
        set_wr(3, 9'h020, 32'h2222FFFF, 4'h3);
        tick();
        idle_inputs();
        set_rd(1, 9'h020);
        tick();
        check("port_priority", bus.rd_data[1*DW +: DW], 32'h1111FFFF);

        // Read and write of the same address in one cycle.
        idle_inputs();
        set_wr(2, 9'h030, 32'hA5A5A5A5, 4'hF);
        set_rd(3, 9'h030);
        tick();
`ifdef DATA_MEM_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h0;
`endif
        check("same_cycle_rw", bus.rd_data[3*DW +: DW], byp_exp);
        idle_inputs();
        set_rd(3, 9'h030);
        tick();
        check("rw_settled", bus.rd_data[3*DW +: DW], 32'hA5A5A5A5);

        // Clear request; write at sweep cycle 3 is dropped; repeat request ignored.
        idle_inputs();
        set_wr(0, 9'h005, 32'h77, 4'hF);
        tick();
        idle_inputs();
        set_rd(0, 9'h005);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick();
        tick();
        set_wr(0, 9'h005, 32'h5, 4'hF);
        tick();
        idle_inputs();
        set_rd(0, 9'h005);
        for (int k = 0; k < 96; k++) tick();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int k = 0; k < DEPTH + 20 && busy_left > 0; k++) tick();
        tick();
        check("addr005_after_clear", bus.rd_data[0 +: DW], 32'h0);

        // Reset at sweep address 200 restarts the full sweep.
        idle_inputs();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int k = 0; k < 200; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        measure_busy(run_len);
        check("reset_mid_sweep_len", run_len, DEPTH);

        // Random traffic over a small address window to force collisions.
        for (int k = 0; k < 600; k++) begin
            idle_inputs();
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(j, AW'($urandom_range(0, 15)), $urandom, BEW'($urandom_range(0, 15)));
            for (int i = 0; i < NRD; i++) set_rd(i, AW'($urandom_range(0, 15)));
            bus.clear_req = ($urandom_range(0, 299) == 0);
            tick();
        end

        idle_inputs();
        for (int k = 0; k < DEPTH + 20 && busy_left > 0; k++) tick();
        tick();
        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
